// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, forwarding sources and ALU-side outputs of the ID/EX register
interface id_ex_stage_if #(parameter int DW = 32, parameter int RW = 5);
   logic          id_valid, stall, flush;
   logic [3:0]    id_alu_control;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [RW-1:0] id_shamt, id_rs, id_rt, id_rd;
   logic [1:0]    id_op_sel;
   logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic          exmem_reg_write, memwb_reg_write;
   logic [RW-1:0] exmem_rd, memwb_rd;
   logic [DW-1:0] exmem_result, memwb_result;
   logic [3:0]    alu_control;
   logic [DW-1:0] alu_a, alu_b, ex_store_data;
   logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [RW-1:0] ex_rd;
   logic          load_use_hazard;
   modport slave (
      input  id_valid, stall, flush, id_alu_control, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_rs, id_rt, id_rd, id_op_sel,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      output alu_control, alu_a, alu_b, ex_store_data, ex_valid, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard
   );
   modport master (
      output id_valid, stall, flush, id_alu_control, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_rs, id_rt, id_rd, id_op_sel,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      input  alu_control, alu_a, alu_b, ex_store_data, ex_valid, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with result forwarding, ALU operand select and load-use bubbling
module id_ex_stage #(parameter int DW = 32, parameter int RW = 5) (
   input logic         clk,
   input logic         reset,
   id_ex_stage_if.slave bus
);
   logic          valid_r, rw_r, mr_r, mw_r, m2r_r;
   logic [3:0]    ctl_r;
   logic [1:0]    op_r;
   logic [DW-1:0] rs_d_r, rt_d_r, imm_r, fwd_rs, fwd_rt;
   logic [RW-1:0] shamt_r, rs_r, rt_r, rd_r;
   logic          hazard, live;

   assign hazard = valid_r & mr_r & (rd_r != '0) & ((rd_r == bus.id_rs) | (rd_r == bus.id_rt)) & bus.id_valid;
   assign live   = bus.id_valid & ~bus.flush & ~hazard;

   // forward the youngest in-flight result for each source; r0 is hard-wired and never forwarded
   always_comb begin
      fwd_rs = (rs_r == '0) ? rs_d_r :
               (bus.exmem_reg_write && bus.exmem_rd == rs_r) ? bus.exmem_result :
               (bus.memwb_reg_write && bus.memwb_rd == rs_r) ? bus.memwb_result : rs_d_r;
      fwd_rt = (rt_r == '0) ? rt_d_r :
               (bus.exmem_reg_write && bus.exmem_rd == rt_r) ? bus.exmem_result :
               (bus.memwb_reg_write && bus.memwb_rd == rt_r) ? bus.memwb_result : rt_d_r;
   end

   // stall keeps everything but refreshes operands so a retiring producer's value is not lost
   always_ff @(posedge clk) begin
      if (reset) begin
         {valid_r, rw_r, mr_r, mw_r, m2r_r} <= '0;
         {ctl_r, op_r, rs_d_r, rt_d_r, imm_r} <= '0;
         {shamt_r, rs_r, rt_r, rd_r} <= '0;
      end else if (bus.stall) begin
         rs_d_r <= fwd_rs;
         rt_d_r <= fwd_rt;
      end else begin
         valid_r <= live;
         ctl_r   <= live ? bus.id_alu_control : 4'b0;
         rw_r    <= live & bus.id_reg_write;
         mr_r    <= live & bus.id_mem_read;
         mw_r    <= live & bus.id_mem_write;
         m2r_r   <= live & bus.id_mem_to_reg;
         op_r    <= bus.id_op_sel;
         rs_d_r  <= bus.id_rs_data;
         rt_d_r  <= bus.id_rt_data;
         imm_r   <= bus.id_imm;
         shamt_r <= bus.id_shamt;
         rs_r    <= bus.id_rs;
         rt_r    <= bus.id_rt;
         rd_r    <= bus.id_rd;
      end
   end

   assign bus.alu_control     = ctl_r;
   assign bus.alu_a           = op_r[1] ? fwd_rt : fwd_rs;
   assign bus.alu_b           = (op_r == 2'b00) ? fwd_rt :
                                (op_r == 2'b01) ? imm_r :
                                (op_r == 2'b10) ? {{(DW-RW){1'b0}}, shamt_r} :
                                                  {{(DW-RW){1'b0}}, fwd_rs[RW-1:0]};
   assign bus.ex_store_data   = fwd_rt;
   assign bus.ex_valid        = valid_r;
   assign bus.ex_rd           = rd_r;
   assign bus.ex_reg_write    = rw_r;
   assign bus.ex_mem_read     = mr_r;
   assign bus.ex_mem_write    = mw_r;
   assign bus.ex_mem_to_reg   = m2r_r;
   assign bus.load_use_hazard = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table with scoreboard queue plus hand sequences for reset, load-use and stall
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;

   id_ex_stage_if #(.DW(32), .RW(5)) bus();
   id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  ctl;
      logic [1:0]  op;
      logic [4:0]  rs;
      logic [31:0] rs_d;
      logic [4:0]  rt;
      logic [31:0] rt_d;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic [3:0]  flags;
      logic        exw;
      logic [4:0]  exrd;
      logic [31:0] exres;
      logic        mww;
      logic [4:0]  mwrd;
      logic [31:0] mwres;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] es;
   } vec_t;

   typedef struct {
      logic        ev;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic [3:0]  flags;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
   } exp_t;

   vec_t vecs[9];
   exp_t sb[$];
   exp_t e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic valid, input logic [3:0] ctl, input logic [1:0] op,
                           input logic [4:0] rs, input logic [31:0] rs_d, input logic [4:0] rt,
                           input logic [31:0] rt_d, input logic [31:0] imm, input logic [4:0] shamt,
                           input logic [4:0] rd, input logic [3:0] flags);
      bus.id_valid = valid;
      bus.id_alu_control = ctl;
      bus.id_op_sel = op;
      bus.id_rs = rs;
      bus.id_rs_data = rs_d;
      bus.id_rt = rt;
      bus.id_rt_data = rt_d;
      bus.id_imm = imm;
      bus.id_shamt = shamt;
      bus.id_rd = rd;
      {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg} = flags;
   endtask

   task automatic drive_fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                            input logic mww, input logic [4:0] mwrd, input logic [31:0] mwres);
      bus.exmem_reg_write = exw;
      bus.exmem_rd = exrd;
      bus.exmem_result = exres;
      bus.memwb_reg_write = mww;
      bus.memwb_rd = mwrd;
      bus.memwb_result = mwres;
   endtask

   function automatic logic [3:0] flags_out();
      return {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg};
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 4'b1000, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, '0, '0, 5'd3, 4'b1000,
                  '0, '0, '0, '0, '0, '0, 32'd5, 32'd7, 32'd7};
      vecs[1] = '{1'b1, 4'b0000, 2'b10, 5'd0, 32'h0, 5'd3, 32'h1, '0, 5'd4, 5'd6, 4'b1000,
                  '0, '0, '0, '0, '0, '0, 32'h1, 32'h4, 32'h1};
      vecs[2] = '{1'b1, 4'b0000, 2'b10, 5'd0, 32'h0, 5'd0, 32'h0, '0, 5'd4, 5'd6, 4'b1000,
                  1'b1, 5'd0, 32'hFF, '0, '0, '0, 32'h0, 32'h4, 32'h0};
      vecs[3] = '{1'b1, 4'b1000, 2'b00, 5'd8, 32'h11, 5'd9, 32'h22, '0, '0, 5'd10, 4'b1000,
                  1'b1, 5'd8, 32'hAAAA, 1'b1, 5'd8, 32'h5555, 32'hAAAA, 32'h22, 32'h22};
      vecs[4] = '{1'b1, 4'b1000, 2'b00, 5'd8, 32'h11, 5'd9, 32'h22, '0, '0, 5'd10, 4'b1000,
                  1'b0, 5'd8, 32'hAAAA, 1'b1, 5'd8, 32'h5555, 32'h5555, 32'h22, 32'h22};
      vecs[5] = '{1'b1, 4'b1010, 2'b01, 5'd6, 32'h100, 5'd7, 32'h33, 32'hFFFF_FFF0, '0, 5'd0, 4'b0010,
                  '0, '0, '0, 1'b1, 5'd7, 32'h77, 32'h100, 32'hFFFF_FFF0, 32'h77};
      vecs[6] = '{1'b1, 4'b0001, 2'b11, 5'd10, 32'h23, 5'd11, 32'h80, '0, 5'd31, 5'd12, 4'b1000,
                  1'b1, 5'd10, 32'hFFFF_FFE5, '0, '0, '0, 32'h80, 32'h5, 32'h80};
      vecs[7] = '{1'b1, 4'b0100, 2'b00, 5'd12, 32'h1, 5'd13, 32'h2, '0, '0, 5'd14, 4'b1001,
                  1'b1, 5'd13, 32'h10, 1'b1, 5'd12, 32'h20, 32'h20, 32'h10, 32'h10};
      vecs[8] = '{1'b0, 4'b1000, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, '0, '0, 5'd3, 4'b1111,
                  '0, '0, '0, '0, '0, '0, 32'd5, 32'd7, 32'd7};

      reset = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b1;
      drive_id(1'b1, 4'b1111, 2'b01, 5'd7, 32'hDEAD, 5'd8, 32'hBEEF, 32'h1234, 5'd3, 5'd9, 4'b1111);
      drive_fwd(1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd8, 32'hF00D);
      tick();
      tick();
      check("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("rst_a", bus.alu_a, 32'd0);
      check("rst_b", bus.alu_b, 32'd0);
      check("rst_ctl", {28'b0, bus.alu_control}, 32'd0);
      check("rst_store", bus.ex_store_data, 32'd0);
      check("rst_rd", {27'b0, bus.ex_rd}, 32'd0);
      check("rst_flags", {28'b0, flags_out()}, 32'd0);
      check("rst_hazard", {31'b0, bus.load_use_hazard}, 32'd0);
      reset = 1'b0;
      bus.flush = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive_id(vecs[i].valid, vecs[i].ctl, vecs[i].op, vecs[i].rs, vecs[i].rs_d, vecs[i].rt,
                  vecs[i].rt_d, vecs[i].imm, vecs[i].shamt, vecs[i].rd, vecs[i].flags);
         drive_fwd(vecs[i].exw, vecs[i].exrd, vecs[i].exres, vecs[i].mww, vecs[i].mwrd, vecs[i].mwres);
         sb.push_back('{vecs[i].valid, vecs[i].valid ? vecs[i].ctl : 4'b0, vecs[i].rd,
                        vecs[i].valid ? vecs[i].flags : 4'b0, vecs[i].ea, vecs[i].eb, vecs[i].es});
         tick();
         e = sb.pop_front();
         check($sformatf("v%0d_valid", i), {31'b0, bus.ex_valid}, {31'b0, e.ev});
         check($sformatf("v%0d_ctl", i), {28'b0, bus.alu_control}, {28'b0, e.ctl});
         check($sformatf("v%0d_rd", i), {27'b0, bus.ex_rd}, {27'b0, e.rd});
         check($sformatf("v%0d_flags", i), {28'b0, flags_out()}, {28'b0, e.flags});
         check($sformatf("v%0d_a", i), bus.alu_a, e.a);
         check($sformatf("v%0d_b", i), bus.alu_b, e.b);
         check($sformatf("v%0d_store", i), bus.ex_store_data, e.s);
         check($sformatf("v%0d_hazard", i), {31'b0, bus.load_use_hazard}, 32'd0);
      end

      drive_fwd('0, '0, '0, '0, '0, '0);
      drive_id(1'b1, 4'b1000, 2'b01, 5'd1, 32'h40, 5'd9, 32'h0, 32'h4, '0, 5'd9, 4'b1101);
      tick();
      check("lu_lw_valid", {31'b0, bus.ex_valid}, 32'd1);
      drive_id(1'b1, 4'b1000, 2'b00, 5'd9, 32'h0, 5'd2, 32'h3, '0, '0, 5'd4, 4'b1000);
      #1;
      check("lu_hazard_hi", {31'b0, bus.load_use_hazard}, 32'd1);
      tick();
      check("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("lu_bubble_flags", {28'b0, flags_out()}, 32'd0);
      check("lu_bubble_ctl", {28'b0, bus.alu_control}, 32'd0);
      check("lu_hazard_lo", {31'b0, bus.load_use_hazard}, 32'd0);
      drive_fwd('0, '0, '0, 1'b1, 5'd9, 32'h99);
      tick();
      check("lu_load_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("lu_load_a", bus.alu_a, 32'h99);
      check("lu_load_b", bus.alu_b, 32'h3);

      drive_fwd('0, '0, '0, '0, '0, '0);
      drive_id(1'b1, 4'b1000, 2'b00, 5'd1, 32'h1, 5'd4, 32'h0, '0, '0, 5'd5, 4'b1000);
      tick();
      bus.stall = 1'b1;
      drive_id(1'b1, 4'b0011, 2'b01, 5'd6, 32'h66, 5'd7, 32'h77, 32'h5, '0, 5'd8, 4'b0010);
      drive_fwd('0, '0, '0, 1'b1, 5'd4, 32'h1234);
      #1;
      check("st_c1_b", bus.alu_b, 32'h1234);
      tick();
      drive_fwd('0, '0, '0, '0, '0, '0);
      #1;
      check("st_c2_b", bus.alu_b, 32'h1234);
      check("st_c2_rd", {27'b0, bus.ex_rd}, 32'd5);
      bus.flush = 1'b1;
      tick();
      check("st_c3_b", bus.alu_b, 32'h1234);
      check("st_c3_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("st_c3_ctl", {28'b0, bus.alu_control}, 32'h8);
      bus.stall = 1'b0;
      tick();
      check("st_flush_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("st_flush_ctl", {28'b0, bus.alu_control}, 32'd0);
      check("st_flush_flags", {28'b0, flags_out()}, 32'd0);
      bus.flush = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU. It captures decoded operands and control, and applies EX/MEM and MEM/WB result forwarding.
- It selects ALU operand A and B, including the shift-operand swap the ALU shifter requires. It detects load-use hazards and inserts bubbles.
- Its outputs drive the ALU `alu_control`/`A`/`B` inputs directly. Store data and destination info pass on to the EX/MEM register.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- stall  in  1  hold all stage contents (external, e.g. memory wait)
- flush  in  1  squash incoming instruction (branch/jump redirect)
- id_alu_control  in  4  ALU op: [3:2]=00 shift, 01 SLT, 10 add/sub, 11 logic
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_shamt  in  RW  instruction shamt field
- id_rs, id_rt, id_rd  in  RW  source indices, destination index
- id_op_sel  in  2  00 A=rs,B=rt; 01 A=rs,B=imm; 10 A=rt,B=shamt; 11 A=rt,B=rs[4:0]
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  downstream control
- exmem_reg_write  in  1; exmem_rd  in  RW; exmem_result  in  DW  EX/MEM forwarding source
- memwb_reg_write  in  1; memwb_rd  in  RW; memwb_result  in  DW  MEM/WB forwarding source
- alu_control  out  4  to ALU
- alu_a, alu_b  out  DW  to ALU
- ex_store_data  out  DW  forwarded rt, for stores
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  registered
- load_use_hazard  out  1  combinational; decode must hold its instruction while high

Behaviour:
- Reset: synchronous, active-high, highest priority. All registered fields are set to 0. Outputs therefore read 0: `alu_a`, `alu_b`, `alu_control`, `ex_store_data`, all `ex_*`.
- `load_use_hazard` = `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs` | `ex_rd`==`id_rt`) & `id_valid`.
- Register update priority each edge: reset > stall > flush > hazard > load.
  - stall: all control and index fields hold. The rs/rt data registers reload with their currently forwarded values, so the operand survives the producer retiring from MEM/WB during a multi-cycle stall.
  - flush (no stall): bubble. `ex_valid` and all `ex_*` control bits go to 0, and `alu_control` goes to 0.
  - hazard (no stall/flush): bubble, identical to flush.
  - otherwise: load all id_* fields. `ex_valid` takes `id_valid`. If `id_valid`=0, control bits load as 0.
- Latency: one cycle from id_* to registered fields. The forwarding and operand muxes are combinational on the register outputs.
- Forwarding, applied to each source (rs, rt) independently:
  - Index 0 is never forwarded and always yields the registered value.
  - If `exmem_reg_write` & `exmem_rd`==src, use `exmem_result`.
  - Else if `memwb_reg_write` & `memwb_rd`==src, use `memwb_result`.
  - Else use the registered data.
  - EX/MEM wins when both sources match.
- Operand select on the forwarded values fwd_rs/fwd_rt:
  - 00: A=fwd_rs, B=fwd_rt
  - 01: A=fwd_rs, B=imm
  - 10: A=fwd_rt, B={27'b0,shamt}
  - 11: A=fwd_rt, B={27'b0,fwd_rs[4:0]}
  - The ALU shifter shifts A by B[4:0], so shift ops must route rt to A.
- `ex_store_data` = fwd_rt, regardless of `op_sel`.
- When `ex_valid`=0, `alu_a`/`alu_b` are still driven from the registers. Consumers must ignore them; control bits are guaranteed 0.
- Simultaneous flush and hazard: the result is one bubble. `load_use_hazard` may still be high, and decode's hold is then harmless because decode is also being flushed.

Test Plan:
- Reset with all inputs nonzero → next edge: `ex_valid`=0, `alu_a`=`alu_b`=0, `alu_control`=0, all control bits 0.
- Load `add`: op_sel=00, rs=1 (data 5), rt=2 (data 7), no forwarding → next cycle `alu_a`=5, `alu_b`=7, `alu_control`=4'b1000, `ex_valid`=1.
- `sll` with rt=3 (data 0x1), shamt=4, op_sel=10 → `alu_a`=0x1, `alu_b`=0x4. Same op with rt=0 and `exmem_rd`=0, `exmem_reg_write`=1, `exmem_result`=0xFF → `alu_a`=0 (r0 not forwarded).
- Double match on rs=8: `exmem_result`=0xAAAA and `memwb_result`=0x5555, both matching → `alu_a`=0xAAAA. Drop `exmem_reg_write` → `alu_a`=0x5555.
- Load-use: EX holds `lw` with `ex_rd`=9; decode presents rs=9 → `load_use_hazard`=1. Next edge `ex_valid`=0 and control bits 0. With decode held, hazard clears and the instruction loads the following cycle.
- Stall for 3 cycles while MEM/WB supplies rt=4 (0x1234) only in cycle 1 → `alu_b` stays 0x1234 through all cycles. A flush asserted together with stall is ignored until stall drops.
